// File: rtl/core_fetch_responder.sv
// Memory-side responder for instruction fetch: issues sequential word reads on a
// pipelined read bus, returns each word as a one-cycle pulse, and drops stale data after a redirect.
module core_fetch_responder #(
  parameter int ADDR_W          = 30,
  parameter int MAX_OUTSTANDING = 1,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              fetched,
  output logic [31:0]       fetch_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [CNT_W:0] MaxOut = (CNT_W + 1)'(MAX_OUTSTANDING);

  state_e              state_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic                mem_read_q;
  logic                fetched_q;
  logic [31:0]         fetch_data_q;
  logic [CNT_W-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0]    discard_q, discard_d;
  logic                stale_q, stale_d;

  logic accept;
  logic rsp;
  logic drop;
  logic deliver;
  logic can_issue;

  assign accept    = mem_read_q && !mem_waitrequest;
  assign rsp       = mem_readdatavalid;
  assign drop      = rsp && (discard_q != '0);
  assign deliver   = rsp && !drop && !flush;
  // Capacity test is (pending - rsp) < MAX, rearranged so it cannot underflow.
  assign can_issue = fetch && !flush &&
                     ({1'b0, pending_q} < (MaxOut + {{CNT_W{1'b0}}, rsp}));

  // NOTE: every always_comb output gets an unconditional default first so no latch is inferred.
  always_comb begin
    pending_d = pending_q + CNT_W'(accept) - CNT_W'(rsp);
    discard_d = discard_q + CNT_W'(accept && stale_q) - CNT_W'(drop);
    stale_d   = stale_q && !accept;
    if (flush) begin
      // Everything still unanswered after this cycle belongs to the old stream.
      discard_d = pending_d;
      stale_d   = (state_q == REQ) && !accept;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      fetched_q     <= 1'b0;
      fetch_data_q  <= '0;
      pending_q     <= '0;
      discard_q     <= '0;
      stale_q       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      discard_q <= discard_d;
      stale_q   <= stale_d;
      fetched_q <= deliver;
      if (deliver) begin
        fetch_data_q <= mem_readdata;
      end
      if (flush) begin
        req_addr_q <= flush_addr;
      end
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            state_q       <= REQ;
            mem_read_q    <= 1'b1;
            mem_address_q <= req_addr_q;
            req_addr_q    <= req_addr_q + ADDR_W'(1);
          end
        end
        REQ: begin
          // The request stays up until accepted, regardless of fetch or flush.
          if (accept) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign fetched     = fetched_q;
  assign fetch_data  = fetch_data_q;
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;

endmodule

// File: tb/tb_core_fetch_responder.sv
// Randomized scoreboard bench: a per-request bus model predicts addresses, issue timing
// and which words must be delivered; a separate monitor compares every fetched pulse.
module tb_core_fetch_responder;

  localparam int ADDR_W = 30;
  localparam int MAXO   = 3;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst;
  logic              fetch;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              fetched;
  logic [31:0]       fetch_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  core_fetch_responder #(
    .ADDR_W         (ADDR_W),
    .MAX_OUTSTANDING(MAXO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch            (fetch),
    .flush            (flush),
    .flush_addr       (flush_addr),
    .fetched          (fetched),
    .fetch_data       (fetch_data),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a < 4) return 32'hA0 + {2'b00, a};
    return {2'b01, a} ^ 32'h2468_ACE1;
  endfunction

  // One accepted bus read: its data, whether the prefetcher must never see it, and when it returns.
  typedef struct {
    logic [31:0] data;
    bit          stale;
    int          due;
  } bus_t;

  // One expected fetched pulse and the cycle it must appear in.
  typedef struct {
    logic [31:0] data;
    int          stamp;
  } exp_t;

  bus_t infl[$];
  exp_t sb[$];

  logic [ADDR_W-1:0] exp_addr  = '0;
  logic [ADDR_W-1:0] open_addr = '0;
  bit req_open     = 0;
  bit req_stale    = 0;
  bit exp_mr       = 0;
  bit exp_mr_valid = 0;
  bit rst_prev     = 0;
  bit last_mr      = 0;
  int lat          = 1;
  int wait_pct     = 0;

  // One bus cycle: observe the DUT, check against the model, drive the next edge, advance the model.
  task automatic step(input bit f, input bit fl, input logic [ADDR_W-1:0] fa,
                      input bit wforce, input bit r);
    bit          mr, w, rv, acc;
    logic [ADDR_W-1:0] ma;
    logic [31:0] rd;
    bus_t        h;
    int          c;
    @(negedge clk);
    c  = cyc;
    mr = (mem_read === 1'b1);
    ma = mem_address;
    last_mr = mr;

    if (rst_prev) begin
      check(mem_read === 1'b0, "rst_mem_read", 64'(mem_read), 0);
      check(mem_address === '0, "rst_mem_address", 64'(mem_address), 0);
      check(fetched === 1'b0, "rst_fetched", 64'(fetched), 0);
      check(fetch_data === '0, "rst_fetch_data", 64'(fetch_data), 0);
    end
    if (exp_mr_valid) check(mr == exp_mr, "mem_read_timing", 64'(mr), 64'(exp_mr));
    if (mr && !req_open) begin
      check(ma == exp_addr, "req_address", 64'(ma), 64'(exp_addr));
      open_addr = exp_addr;
      exp_addr  = exp_addr + 1'b1;
      req_open  = 1;
      req_stale = 0;
    end else if (mr) begin
      check(ma == open_addr, "address_hold", 64'(ma), 64'(open_addr));
    end

    w  = wforce ? 1'b1 : ($urandom_range(99) < wait_pct);
    rv = 0;
    rd = $urandom;
    if (!r && infl.size() > 0 && infl[0].due <= c + 1) begin
      h  = infl.pop_front();
      rv = 1;
      rd = h.data;
    end
    rst               = r;
    fetch             = f;
    flush             = fl;
    flush_addr        = fl ? fa : ADDR_W'($urandom);
    mem_waitrequest   = w;
    mem_readdatavalid = rv;
    mem_readdata      = rd;
    rst_prev          = r;

    if (r) begin
      infl.delete();
      exp_addr     = '0;
      req_open     = 0;
      exp_mr       = 0;
      exp_mr_valid = 1;
      return;
    end

    acc = mr && !w;
    if (rv && !h.stale && !fl) sb.push_back('{h.data, c + 1});
    if (acc) begin
      infl.push_back('{mem_word(open_addr), req_stale, c + 1 + lat});
      req_open = 0;
      check(infl.size() <= MAXO, "max_outstanding", 64'(infl.size()), 64'(MAXO));
    end
    if (fl) begin
      foreach (infl[i]) infl[i].stale = 1;
      req_stale = 1;
      exp_addr  = fa;
    end
    exp_mr_valid = 1;
    if (!mr) exp_mr = f && !fl && (infl.size() < MAXO);
    else     exp_mr = !acc;
  endtask

  // Monitor: every fetched pulse must match the head of the scoreboard in data and cycle.
  always @(negedge clk) begin
    bit due;
    bit exp_v;
    due   = (sb.size() > 0) && (sb[0].stamp <= cyc);
    exp_v = due && (sb[0].stamp == cyc);
    if (fetched === 1'b1 || due) begin
      check((fetched === 1'b1) == exp_v, "fetched_pulse", 64'(fetched), 64'(exp_v));
      if (fetched === 1'b1 && exp_v)
        check(fetch_data == sb[0].data, "fetch_data", 64'(fetch_data), 64'(sb[0].data));
      if (due) void'(sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; fetch = 1'b0; flush = 1'b0; flush_addr = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;

    repeat (3) step(0, 0, '0, 0, 1);

    // Zero-wait bus, one-cycle response: words 0xA0.. in order.
    lat = 1; wait_pct = 0;
    repeat (14) step(1, 0, '0, 0, 0);
    repeat (6)  step(0, 0, '0, 0, 0);

    // Stall at address 5 while fetch drops.
    step(0, 1, 30'd5, 0, 0);
    for (int i = 0; i < 10 && !last_mr; i++) step(1, 0, '0, 1, 0);
    check(last_mr, "reach_req_addr5", 64'(last_mr), 1);
    repeat (4) step(0, 0, '0, 1, 0);
    repeat (6) step(0, 0, '0, 0, 0);

    // Long latency: outstanding limit and simultaneous accept/response.
    lat = 6;
    repeat (40) step(1, 0, '0, 0, 0);
    repeat (10) step(0, 0, '0, 0, 0);

    // Flush with two reads outstanding.
    for (int i = 0; i < 20 && infl.size() != 2; i++) step(1, 0, '0, 0, 0);
    check(infl.size() == 2, "reach_two_outstanding", 64'(infl.size()), 2);
    step(1, 1, 30'h100, 0, 0);
    repeat (30) step(1, 0, '0, 0, 0);
    repeat (10) step(0, 0, '0, 0, 0);

    // Flush while a request is stalled, accepted three cycles later.
    lat = 2;
    last_mr = 0;
    for (int i = 0; i < 10 && !last_mr; i++) step(1, 0, '0, 1, 0);
    check(last_mr, "reach_req_stalled", 64'(last_mr), 1);
    step(0, 1, 30'h200, 1, 0);
    repeat (2) step(0, 0, '0, 1, 0);
    repeat (20) step(1, 0, '0, 0, 0);
    repeat (6)  step(0, 0, '0, 0, 0);

    // Address wrap at the top of the word space.
    step(0, 1, 30'h3FFF_FFFE, 0, 0);
    repeat (12) step(1, 0, '0, 0, 0);
    repeat (6)  step(0, 0, '0, 0, 0);

    // Randomized traffic with stalls and redirects at several latencies.
    wait_pct = 30;
    for (int l = 1; l <= 5; l += 2) begin
      lat = l;
      repeat (200) step($urandom_range(3) != 0, $urandom_range(19) == 0,
                        ADDR_W'($urandom), 0, 0);
    end
    wait_pct = 0;
    repeat (12) step(0, 0, '0, 0, 0);

    // Reset while a request is waiting with one read outstanding.
    lat = 4;
    for (int i = 0; i < 10 && infl.size() != 1; i++) step(1, 0, '0, 0, 0);
    last_mr = 0;
    for (int i = 0; i < 10 && !last_mr; i++) step(1, 0, '0, 1, 0);
    check(last_mr && infl.size() == 1, "reach_req_pending1", 64'(infl.size()), 1);
    step(0, 0, '0, 0, 1);
    repeat (16) step(1, 0, '0, 0, 0);
    repeat (12) step(0, 0, '0, 0, 0);

    @(negedge clk);
    #1;
    check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
